mem_port_arbiter: RTL

- Shares one unified, variable-latency memory port between the pipeline's instruction-fetch requester (IF stage) and its data requester (MEM stage, LWD/SWD).
- Sits between the pipelined datapath and external memory.
- Sequences each access with a req/ack handshake to memory and returns a one-cycle ready pulse to the requester.
- Data accesses take priority over fetches, with a bounded-starvation guarantee for fetch.

---
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch and data access.
// Data wins by default; a fetch is forced through after STARVE_LIMIT consecutive data wins.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no access in flight; arbitrate on each rising edge
// I_ACCESS | fetch access in flight; waiting for mem_ack
// D_ACCESS | data load/store in flight; waiting for mem_ack
module mem_port_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_readM,
    input  logic [WORD_SIZE-1:0] i_address,
    output logic [WORD_SIZE-1:0] i_data,
    output logic                 i_ready,
    input  logic                 d_readM,
    input  logic                 d_writeM,
    input  logic [WORD_SIZE-1:0] d_address,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_address,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack,
    output logic [1:0]           grant_owner
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] I_ACCESS = 2'd1;
    localparam logic [1:0] D_ACCESS = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] starveCnt;
    logic             dEligible;
    logic             iEligible;
    logic             grantData;
    logic             grantFetch;

    // The !ready terms stop a request still held during its own ready pulse from being re-granted.
    assign dEligible = (d_readM | d_writeM) & ~d_ready;
    assign iEligible = i_readM & ~i_ready;

    always_comb begin
        grantData  = dEligible & ~(iEligible & (starveCnt == STARVE_MAX));
        grantFetch = iEligible & ~grantData;
    end

    // State encoding matches the owner code, so the owner output is the state register itself.
    assign grant_owner = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            starveCnt   <= '0;
            i_data      <= '0;
            i_ready     <= 1'b0;
            d_rdata     <= '0;
            d_ready     <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (grantData) begin
                        state       <= D_ACCESS;
                        mem_req     <= 1'b1;
                        mem_we      <= d_writeM;
                        mem_address <= d_address;
                        mem_wdata   <= d_wdata;
                        if (iEligible)
                            starveCnt <= (starveCnt == STARVE_MAX) ? STARVE_MAX : starveCnt + 1'b1;
                        else
                            starveCnt <= '0;
                    end else if (grantFetch) begin
                        state       <= I_ACCESS;
                        mem_req     <= 1'b1;
                        mem_we      <= 1'b0;
                        mem_address <= i_address;
                        starveCnt   <= '0;
                    end
                end
                I_ACCESS: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        i_ready <= 1'b1;
                        i_data  <= mem_rdata;
                    end
                end
                D_ACCESS: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        d_ready <= 1'b1;
                        if (!mem_we)
                            d_rdata <= mem_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
